// File: rtl/tlb_memtype_ranges.sv
// tlb_memtype_ranges: programmable base/limit/attr table classifying TLB
// physical addresses as cache-disabled / write-transparent, 1-cycle result.
// Ports: clk, rst_n (async low); cfg_write/cfg_index/cfg_field/cfg_data
// program the table; req_valid/req_physical -> rsp_valid, rsp_cache_disable,
// rsp_write_transparent, rsp_hit, rsp_region; table_changed = flush pulse.
// Optional macro TLB_MEMTYPE_READBACK_EN adds cfg_read -> cfg_rdata,
// rdata_valid (registered field readback).
module tlb_memtype_ranges #(
  parameter int REGIONS = 4,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_write,
  input  logic [IDX_W-1:0] cfg_index,
  input  logic [1:0]       cfg_field,
  input  logic [27:0]      cfg_data,
  input  logic             req_valid,
  input  logic [31:0]      req_physical,
  output logic             rsp_valid,
  output logic             rsp_cache_disable,
  output logic             rsp_write_transparent,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_region,
  output logic             table_changed
`ifdef TLB_MEMTYPE_READBACK_EN
  ,
  input  logic             cfg_read,
  output logic [27:0]      cfg_rdata,
  output logic             rdata_valid
`endif
);

  localparam logic [1:0] F_BASE  = 2'd0;
  localparam logic [1:0] F_LIMIT = 2'd1;
  localparam logic [1:0] F_ATTR  = 2'd2;

  logic [27:0] r_base  [REGIONS];
  logic [27:0] r_limit [REGIONS];
  logic [2:0]  r_attr  [REGIONS];

  logic             r_rsp_valid;
  logic             r_rsp_cd;
  logic             r_rsp_wt;
  logic             r_rsp_hit;
  logic [IDX_W-1:0] r_rsp_region;
  logic             r_changed;

  logic [27:0]      w_pa;
  logic             w_unused_lsb;
  logic             w_idx_ok;
  logic [IDX_W-1:0] w_idx;
  logic             w_fld_ok;
  logic             w_wr_ok;
  logic [27:0]      w_cur;
  logic [27:0]      w_new;
  logic             w_diff;
  logic             w_hit;
  logic [IDX_W-1:0] w_region;
  logic             w_cd;
  logic             w_wt;

  // Only the 16-byte granule takes part in the compare.
  assign w_pa         = req_physical[31:4];
  assign w_unused_lsb = ^req_physical[3:0];

  assign w_idx_ok = (int'(cfg_index) < REGIONS);
  assign w_idx    = w_idx_ok ? cfg_index : '0;
  assign w_fld_ok = (cfg_field != 2'd3);
  assign w_wr_ok  = cfg_write && w_idx_ok && w_fld_ok;

  // Currently stored value of the addressed field (attr zero-extended).
  always_comb begin
    w_cur = '0;
    unique case (1'b1)
      (cfg_field == F_BASE):  w_cur = r_base[w_idx];
      (cfg_field == F_LIMIT): w_cur = r_limit[w_idx];
      (cfg_field == F_ATTR):  w_cur = {25'd0, r_attr[w_idx]};
      default:                w_cur = '0;
    endcase
  end

  // Attr keeps only bits [2:0]; upper data bits cannot cause a flush.
  assign w_new  = (cfg_field == F_ATTR) ? {25'd0, cfg_data[2:0]}
                                        : cfg_data;
  assign w_diff = (w_new != w_cur);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGIONS; i++) begin
        r_base[i]  <= '0;
        r_limit[i] <= '0;
        r_attr[i]  <= '0;
      end
      // Legacy VGA window 0xA0000..0xBFFFF, uncached + write-transparent.
      r_base[0]  <= 28'h000A000;
      r_limit[0] <= 28'h000C000;
      r_attr[0]  <= 3'b111;
    end else if (w_wr_ok) begin
      unique case (1'b1)
        (cfg_field == F_BASE):  r_base[w_idx]  <= cfg_data;
        (cfg_field == F_LIMIT): r_limit[w_idx] <= cfg_data;
        (cfg_field == F_ATTR):  r_attr[w_idx]  <= cfg_data[2:0];
        default: ;
      endcase
    end
  end

  // Scan high to low so the lowest matching index is the last writer.
  // base >= limit can never satisfy both compares, so no extra check.
  always_comb begin
    w_hit    = 1'b0;
    w_region = '0;
    w_cd     = 1'b0;
    w_wt     = 1'b0;
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if (r_attr[i][2] &&
          (r_base[i] <= w_pa) &&
          (w_pa < r_limit[i])) begin
        w_hit    = 1'b1;
        w_region = IDX_W'(i);
        w_cd     = r_attr[i][0];
        w_wt     = r_attr[i][1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_cd     <= 1'b0;
      r_rsp_wt     <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_region <= '0;
    end else begin
      r_rsp_valid <= req_valid;
      if (req_valid) begin
        r_rsp_cd     <= w_cd;
        r_rsp_wt     <= w_wt;
        r_rsp_hit    <= w_hit;
        r_rsp_region <= w_region;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_changed <= 1'b0;
    else        r_changed <= w_wr_ok && w_diff;
  end

  assign rsp_valid             = r_rsp_valid;
  assign rsp_cache_disable     = r_rsp_cd;
  assign rsp_write_transparent = r_rsp_wt;
  assign rsp_hit               = r_rsp_hit;
  assign rsp_region            = r_rsp_region;
  assign table_changed         = r_changed;

`ifdef TLB_MEMTYPE_READBACK_EN
  logic [27:0] r_rdata;
  logic        r_rdata_valid;

  // Reads sample pre-edge state, so a same-cycle write returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= cfg_read;
      if (cfg_read)
        r_rdata <= (w_idx_ok && w_fld_ok) ? w_cur : '0;
    end
  end

  assign cfg_rdata   = r_rdata;
  assign rdata_valid = r_rdata_valid;
`endif

endmodule
